// File: rtl/hdr_pkg.sv
// Shared types and constants for the two-exposure HDR merge stream.
package hdr_pkg;

    typedef enum logic [1:0] {
        MODE_MERGE = 2'd0,
        MODE_PASS0 = 2'd1,
        MODE_PASS1 = 2'd2
    } hdr_mode_e;

    typedef struct packed {
        logic sop;
        logic eop;
    } hdr_side_t;

    localparam int unsigned LAT       = 4;
    localparam int unsigned OUT_W_OFS = 2;

    // Encoding 3 is reserved and behaves as merge.
    function automatic hdr_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_PASS0;
            2'd2:    return MODE_PASS1;
            default: return MODE_MERGE;
        endcase
    endfunction

endpackage

// File: rtl/hdr_merge_pixel.sv
// One colour channel of the HDR merge: fixed 4-stage pipeline, no stall, no reset.
module hdr_merge_pixel
    import hdr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WB         = 4,
    parameter int unsigned GAIN_SHIFT = 2
) (
    input  logic                            clk,
    input  logic [DATA_WIDTH-1:0]           d0,
    input  logic [DATA_WIDTH-1:0]           d1,
    input  hdr_mode_e                       mode,
    output logic [DATA_WIDTH+OUT_W_OFS-1:0] out
);

    localparam int unsigned OUT_W = DATA_WIDTH + OUT_W_OFS;
    localparam int unsigned G_W   = DATA_WIDTH + GAIN_SHIFT;
    localparam int unsigned WI_W  = WB + 1;
    localparam int unsigned P1_W  = DATA_WIDTH + WB + 1;
    localparam int unsigned P0_W  = G_W + WB;
    localparam int unsigned SUM_W = DATA_WIDTH + WB + 4;
    localparam int unsigned SH_W  = SUM_W - WB;
    localparam int unsigned W_ONE = 1 << WB;
    localparam logic [SH_W-1:0] SAT_LIM = SH_W'((1 << OUT_W) - 1);

    logic [DATA_WIDTH-1:0] d0_s1_q, d1_s1_q, d1_s2_q, d1_s3_q;
    hdr_mode_e             mode_s1_q, mode_s2_q, mode_s3_q;
    logic [P1_W-1:0]       p1_s2_q;
    logic [P0_W-1:0]       p0_s2_q;
    logic [G_W-1:0]        g_s2_q, g_s3_q;
    logic [SUM_W-1:0]      sum_s3_q;

    logic [WB-1:0]         w_c;
    logic [WI_W-1:0]       inv_w_c;
    logic [G_W-1:0]        g_c;
    logic [SH_W-1:0]       sh_c;
    logic [OUT_W-1:0]      out_d;

    always_comb begin
        w_c     = d1_s1_q[DATA_WIDTH-1 -: WB];
        inv_w_c = WI_W'(W_ONE) - WI_W'(w_c);
        g_c     = G_W'(d0_s1_q) << GAIN_SHIFT;
        sh_c    = SH_W'(sum_s3_q >> WB);
    end

    // Final stage: saturating merge or one of the bypass paths.
    always_comb begin
        out_d = '0;
        case (mode_s3_q)
            MODE_PASS0: out_d = OUT_W'(g_s3_q);
            MODE_PASS1: out_d = OUT_W'(d1_s3_q);
            default:    out_d = (sh_c > SAT_LIM) ? OUT_W'(SAT_LIM) : sh_c[OUT_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        d0_s1_q   <= d0;
        d1_s1_q   <= d1;
        mode_s1_q <= mode;

        p1_s2_q   <= P1_W'(inv_w_c) * P1_W'(d1_s1_q);
        p0_s2_q   <= P0_W'(w_c) * P0_W'(g_c);
        g_s2_q    <= g_c;
        d1_s2_q   <= d1_s1_q;
        mode_s2_q <= mode_s1_q;

        sum_s3_q  <= SUM_W'(p1_s2_q) + SUM_W'(p0_s2_q);
        g_s3_q    <= g_s2_q;
        d1_s3_q   <= d1_s2_q;
        mode_s3_q <= mode_s2_q;

        out       <= out_d;
    end

endmodule

// File: rtl/hdr_merge_stream.sv
// N-channel HDR merge stream: per-channel pipelines, sideband shift register,
// credit-controlled skid FIFO, frame counter and protocol-error flag.
module hdr_merge_stream
    import hdr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned WB         = 4,
    parameter int unsigned GAIN_SHIFT = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1:0]                             mode_i,
    input  logic                                   asi_snk_valid_i,
    output logic                                   asi_snk_ready_o,
    input  logic [N_CH*DATA_WIDTH-1:0]             asi_snk_0_data_i,
    input  logic [N_CH*DATA_WIDTH-1:0]             asi_snk_1_data_i,
    input  logic                                   asi_snk_startofpacket_i,
    input  logic                                   asi_snk_endofpacket_i,
    output logic                                   aso_src_valid_o,
    input  logic                                   aso_src_ready_i,
    output logic [N_CH*(DATA_WIDTH+OUT_W_OFS)-1:0] aso_src_data_o,
    output logic                                   aso_src_startofpacket_o,
    output logic                                   aso_src_endofpacket_o,
    output logic [15:0]                            frame_cnt_o,
    output logic                                   sop_err_o
);

    localparam int unsigned CH_OW  = DATA_WIDTH + OUT_W_OFS;
    localparam int unsigned BUS_W  = N_CH * CH_OW;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + LAT + 1);

    logic                  accept_c, push_c, pop_c;
    hdr_mode_e             mode_q, beat_mode_c;
    logic                  in_pkt_q;
    logic [LAT-1:0]        v_q;
    hdr_side_t [LAT-1:0]   side_q;
    logic [BUS_W-1:0]      pix_out;
    logic [CNT_W-1:0]      pipe_cnt_c;

    logic [BUS_W-1:0]      mem_data_q [FIFO_DEPTH];
    hdr_side_t             mem_side_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]     count_q, count_d;
    logic [BUS_W-1:0]      head_data_d;
    hdr_side_t             head_side_d;

    assign accept_c    = asi_snk_valid_i & asi_snk_ready_o;
    assign beat_mode_c = (accept_c && asi_snk_startofpacket_i) ? decode_mode(mode_i) : mode_q;
    assign push_c      = v_q[LAT-1];
    assign pop_c       = aso_src_valid_o & aso_src_ready_i;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        hdr_merge_pixel #(
            .DATA_WIDTH (DATA_WIDTH),
            .WB         (WB),
            .GAIN_SHIFT (GAIN_SHIFT)
        ) u_pix (
            .clk  (clk),
            .d0   (asi_snk_0_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .d1   (asi_snk_1_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .mode (beat_mode_c),
            .out  (pix_out[c*CH_OW +: CH_OW])
        );
    end

    // Beats in flight are pre-charged against FIFO space so the FIFO cannot overflow.
    always_comb begin
        pipe_cnt_c = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            pipe_cnt_c = pipe_cnt_c + CNT_W'(v_q[i]);
        end
    end

    assign asi_snk_ready_o = (CNT_W'(count_q) + pipe_cnt_c) < CNT_W'(FIFO_DEPTH);
    assign aso_src_valid_o = (count_q != '0);

    // Next head-of-FIFO; a write into an empty (or draining-to-empty) FIFO bypasses the RAM.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        count_d     = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
        head_data_d = '0;
        head_side_d = '0;
        if (count_d != '0) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                head_data_d = pix_out;
                head_side_d = side_q[LAT-1];
            end else begin
                head_data_d = mem_data_q[rd_ptr_d];
                head_side_d = mem_side_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data_q[wr_ptr_q] <= pix_out;
            mem_side_q[wr_ptr_q] <= side_q[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q                  <= MODE_MERGE;
            in_pkt_q                <= 1'b0;
            v_q                     <= '0;
            side_q                  <= '0;
            wr_ptr_q                <= '0;
            rd_ptr_q                <= '0;
            count_q                 <= '0;
            aso_src_data_o          <= '0;
            aso_src_startofpacket_o <= 1'b0;
            aso_src_endofpacket_o   <= 1'b0;
            frame_cnt_o             <= '0;
            sop_err_o               <= 1'b0;
        end else begin
            mode_q   <= beat_mode_c;
            v_q      <= {v_q[LAT-2:0], accept_c};
            side_q   <= {side_q[LAT-2:0], hdr_side_t'{sop: asi_snk_startofpacket_i,
                                                     eop: asi_snk_endofpacket_i}};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;

            aso_src_data_o          <= head_data_d;
            aso_src_startofpacket_o <= head_side_d.sop;
            aso_src_endofpacket_o   <= head_side_d.eop;

            if (pop_c && aso_src_endofpacket_o) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end

            if (accept_c) begin
                if (asi_snk_startofpacket_i && in_pkt_q) begin
                    sop_err_o <= 1'b1;
                end
                if (asi_snk_endofpacket_i) begin
                    in_pkt_q <= 1'b0;
                end else if (asi_snk_startofpacket_i) begin
                    in_pkt_q <= 1'b1;
                end
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        push_c |-> (count_q < FCNT_W'(FIFO_DEPTH)));

endmodule
